// File: rtl/fitbit_pkg.sv
// Shared constants, MODE encoding and saturating-add helper for the
// pedometer statistics path and the display mux that consumes it.
package fitbit_pkg;

  localparam int STAT_W  = 14;
  localparam int SAT_MAX = 9999;
  localparam int WIN_W   = 7;

  localparam logic [STAT_W-1:0] SAT_MAX_V  = STAT_W'(SAT_MAX);
  localparam logic [STAT_W-1:0] DIST_MAX_V = STAT_W'(9995);
  localparam logic [STAT_W-1:0] DIST_INC_V = STAT_W'(5);
  localparam logic [STAT_W-1:0] STAT_ONE   = STAT_W'(1);

  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(127);
  localparam logic [WIN_W-1:0] THR_32  = WIN_W'(32);
  localparam logic [WIN_W-1:0] THR_64  = WIN_W'(64);

  typedef enum logic [2:0] {
    M_TOTAL = 3'd0,
    M_DIST  = 3'd1,
    M_32    = 3'd2,
    M_64    = 3'd3
  } mode_e;

  // Adds amt unless the result would pass lim; v is assumed to never exceed lim.
  function automatic logic [STAT_W-1:0] sat_add(
    input logic [STAT_W-1:0] v,
    input logic [STAT_W-1:0] amt,
    input logic [STAT_W-1:0] lim
  );
    if (v > (lim - amt)) begin
      return v;
    end
    return v + amt;
  endfunction

endpackage

// File: rtl/step_stats_tracker_if.sv
// Bundle between the step statistics tracker and its consumer (display mux).
// No handshake: pulse is a raw level from the sensor, every output is a
// free-running registered level that the consumer may sample on any cycle.
interface step_stats_tracker_if;
  import fitbit_pkg::*;

  logic              pulse;
  mode_e             MODE;
  logic [STAT_W-1:0] totalSteps;
  logic [STAT_W-1:0] distanceCovered;
  logic [STAT_W-1:0] thirtyTwoStepsPerSecond;
  logic [STAT_W-1:0] sixtyFourStepsPerSecond;
  logic              secTick;
  logic              saturated;

  modport master (
    input  pulse,
    output MODE, totalSteps, distanceCovered,
    output thirtyTwoStepsPerSecond, sixtyFourStepsPerSecond,
    output secTick, saturated
  );

  modport slave (
    output pulse,
    input  MODE, totalSteps, distanceCovered,
    input  thirtyTwoStepsPerSecond, sixtyFourStepsPerSecond,
    input  secTick, saturated
  );

endinterface

// File: rtl/second_tick_gen.sv
// Free-running one-second timer; secTick is a registered strobe that is high
// for the single cycle in which the count sits at CLK_HZ-1.
module second_tick_gen #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic secTick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    // Strobe is registered alongside the count so it lines up with cnt == LAST.
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign secTick = tick_q;

endmodule

// File: rtl/step_stats_tracker.sv
// Turns a raw pedometer pulse into saturating step, distance and per-second
// activity counts, plus the rotating MODE select for the 4-way display mux.
module step_stats_tracker
  import fitbit_pkg::*;
#(
  parameter int CLK_HZ              = 100000000,
  parameter int STEPS_PER_HALF_MILE = 1024,
  parameter int MODE_SECONDS        = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  step_stats_tracker_if.master bus
);

  localparam int HM_W = (STEPS_PER_HALF_MILE > 1) ? $clog2(STEPS_PER_HALF_MILE) : 1;
  localparam logic [HM_W-1:0] HM_LAST = HM_W'(STEPS_PER_HALF_MILE - 1);
  localparam int MS_W = (MODE_SECONDS > 1) ? $clog2(MODE_SECONDS) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MODE_SECONDS - 1);

  logic sec_tick;

  second_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_second_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .secTick (sec_tick)
  );

  // Input path: two synchronizer flops, one history flop, registered edge.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic step_evt_q, step_evt_d;

  always_comb begin
    sync1_d    = bus.pulse;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    step_evt_d = sync2_q & ~sync3_q;
  end

  logic [STAT_W-1:0] total_q, total_d;
  logic              saturated_q, saturated_d;
  logic [HM_W-1:0]   half_cnt_q, half_cnt_d;
  logic [STAT_W-1:0] dist_q, dist_d;
  logic              half_wrap;

  always_comb begin
    total_d    = total_q;
    half_cnt_d = half_cnt_q;
    dist_d     = dist_q;
    half_wrap  = step_evt_q && (half_cnt_q == HM_LAST);
    if (step_evt_q) begin
      total_d    = sat_add(total_q, STAT_ONE, SAT_MAX_V);
      // The half-mile counter keeps running after totalSteps has saturated.
      half_cnt_d = half_wrap ? '0 : half_cnt_q + HM_W'(1);
    end
    if (half_wrap) begin
      dist_d = sat_add(dist_q, DIST_INC_V, DIST_MAX_V);
    end
    saturated_d = (total_d == SAT_MAX_V);
  end

  logic [WIN_W-1:0]  win_q, win_d;
  logic [WIN_W-1:0]  win_sum;
  logic [STAT_W-1:0] t32_q, t32_d;
  logic [STAT_W-1:0] t64_q, t64_d;

  always_comb begin
    // A step landing on the secTick cycle belongs to the second that is ending.
    win_sum = (step_evt_q && (win_q != WIN_MAX)) ? win_q + WIN_W'(1) : win_q;
    win_d   = win_sum;
    t32_d   = t32_q;
    t64_d   = t64_q;
    if (sec_tick) begin
      win_d = '0;
      if (win_sum >= THR_32) begin
        t32_d = sat_add(t32_q, STAT_ONE, SAT_MAX_V);
      end
      if (win_sum >= THR_64) begin
        t64_d = sat_add(t64_q, STAT_ONE, SAT_MAX_V);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      step_evt_q  <= 1'b0;
      total_q     <= '0;
      saturated_q <= 1'b0;
      half_cnt_q  <= '0;
      dist_q      <= '0;
      win_q       <= '0;
      t32_q       <= '0;
      t64_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      step_evt_q  <= step_evt_d;
      total_q     <= total_d;
      saturated_q <= saturated_d;
      half_cnt_q  <= half_cnt_d;
      dist_q      <= dist_d;
      win_q       <= win_d;
      t32_q       <= t32_d;
      t64_q       <= t64_d;
    end
  end

  // MODE rotation: state register / next-state / output.
  mode_e           mode_q, mode_d;
  logic [MS_W-1:0] sec_cnt_q, sec_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= M_TOTAL;
      sec_cnt_q <= '0;
    end else begin
      mode_q    <= mode_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    sec_cnt_d = sec_cnt_q;
    if (sec_tick) begin
      if (sec_cnt_q == MS_LAST) begin
        sec_cnt_d = '0;
        case (mode_q)
          M_TOTAL: mode_d = M_DIST;
          M_DIST:  mode_d = M_32;
          M_32:    mode_d = M_64;
          default: mode_d = M_TOTAL;
        endcase
      end else begin
        sec_cnt_d = sec_cnt_q + MS_W'(1);
      end
    end
  end

  always_comb begin
    bus.MODE                    = mode_q;
    bus.totalSteps              = total_q;
    bus.distanceCovered         = dist_q;
    bus.thirtyTwoStepsPerSecond = t32_q;
    bus.sixtyFourStepsPerSecond = t64_q;
    bus.secTick                 = sec_tick;
    bus.saturated               = saturated_q;
  end

endmodule
